// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready front-end for the shared combinational ALU.
// Registers the operands and control code, holds them stable for a settle
// window (one cycle for simple ops, MULDIV_WAIT cycles for mul/div), then
// captures the 64-bit result into HI/LO and offers it on a response port.
module alu_sequencer #(
  parameter int REG_SIZE    = 32,
  parameter int MULDIV_WAIT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [REG_SIZE-1:0]   req_a,
  input  logic [REG_SIZE-1:0]   req_b,
  output logic [3:0]            alu_ctrl,
  output logic [REG_SIZE-1:0]   alu_a,
  output logic [REG_SIZE-1:0]   alu_b,
  input  logic [2*REG_SIZE-1:0] alu_c,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [REG_SIZE-1:0]   resp_lo,
  output logic [REG_SIZE-1:0]   resp_hi,
  output logic                  resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_e;

  // Counter preload: the capture happens on the edge where the count reads 0.
  localparam logic [3:0] CNT_INIT = 4'(MULDIV_WAIT - 1);

  state_e              state_q, state_d;
  logic [3:0]          ctrl_q, ctrl_d;
  logic [REG_SIZE-1:0] a_q, a_d;
  logic [REG_SIZE-1:0] b_q, b_d;
  logic [REG_SIZE-1:0] lo_q, lo_d;
  logic [REG_SIZE-1:0] hi_q, hi_d;
  logic                err_q, err_d;
  logic [3:0]          cnt_q, cnt_d;

  logic                muldiv_s;
  logic [REG_SIZE-1:0] cap_lo_s;
  logic [REG_SIZE-1:0] cap_hi_s;

  // Capture values: the high word is only meaningful for mul/div, so it is
  // masked for every other op (ror/rol leave stale bits in the upper half).
  always_comb begin
    muldiv_s = (ctrl_q[3:1] == 3'b100);
    cap_lo_s = alu_c[REG_SIZE-1:0];
    if (muldiv_s) begin
      cap_hi_s = alu_c[2*REG_SIZE-1:REG_SIZE];
    end else begin
      cap_hi_s = '0;
    end
  end

  // Next-state and datapath-register update for the four-state sequencer.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ctrl_d = req_op;
          a_d    = req_a;
          b_d    = req_b;
          err_d  = 1'b0;
          if ((req_op[3:2] == 2'b11) ||
              ((req_op == 4'b1001) && (req_b == '0))) begin
            // Illegal op or divide by zero: answer immediately with an error.
            lo_d    = '0;
            hi_d    = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else if (req_op[3:1] == 3'b100) begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end else begin
            state_d = EXEC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        lo_d    = cap_lo_s;
        hi_d    = cap_hi_s;
        state_d = DONE;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          lo_d    = cap_lo_s;
          hi_d    = cap_hi_s;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = WAIT;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ctrl_q  <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs are decoded from state only, never from the inputs.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);

  assign alu_ctrl = ctrl_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign resp_lo  = lo_q;
  assign resp_hi  = hi_q;
  assign resp_err = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, reference model and a scoreboard
// whose monitor checks every response, its latency and its stability.
module tb_alu_sequencer;

  localparam int RS = 32;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = 4'd0;
  logic [RS-1:0] req_a = '0;
  logic [RS-1:0] req_b = '0;
  logic [3:0]    alu_ctrl;
  logic [RS-1:0] alu_a;
  logic [RS-1:0] alu_b;
  logic [2*RS-1:0] alu_c;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [RS-1:0] resp_lo;
  logic [RS-1:0] resp_hi;
  logic          resp_err;

  alu_sequencer #(.REG_SIZE(RS), .MULDIV_WAIT(MW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_lo(resp_lo), .resp_hi(resp_hi), .resp_err(resp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rr_mode = 0;   // 0: resp_ready low, 1: high, 2: random
  logic        in_resp = 1'b0;
  logic [64:0] held = '0;
  logic [3:0]  cur_op = 4'd0;
  logic [31:0] cur_a = '0;
  logic [31:0] cur_b = '0;
  logic [3:0]  rop;
  logic [31:0] ra, rb;

  // Combinational ALU stand-in; upper word carries junk for single-word ops.
  function automatic logic [63:0] alu_model(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] junk;
    logic [4:0]  s;
    logic signed [63:0] p;
    junk = a ^ 32'hA5A5_5A5A;
    s = b[4:0];
    case (op)
      4'd0:  return {junk, a & b};
      4'd1:  return {junk, a | b};
      4'd2:  return {junk, a + b};
      4'd3:  return {junk, a - b};
      4'd4:  return {junk, a >> s};
      4'd5:  return {junk, a << s};
      4'd6:  return {junk, (a >> s) | (a << (6'd32 - {1'b0, s}))};
      4'd7:  return {junk, (a << s) | (a >> (6'd32 - {1'b0, s}))};
      4'd8: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      4'd9:  return (b == 32'd0) ? 64'hDEAD_BEEF_DEAD_BEEF : {a % b, a / b};
      4'd10: return {junk, -a};
      4'd11: return {junk, ~a};
      default: return {junk, junk};
    endcase
  endfunction

  always_comb alu_c = alu_model(alu_ctrl, alu_a, alu_b);

  // Reference: what the consumer should see for one request, and after how many edges.
  function automatic exp_t ref_model(input logic [3:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    exp_t e;
    logic [63:0] dbl;
    longint sp;
    e.lo = 32'd0; e.hi = 32'd0; e.err = 1'b0; e.lat = 2; e.acc_cyc = 0;
    dbl = {a, a};
    case (op)
      4'd0:  e.lo = a & b;
      4'd1:  e.lo = a | b;
      4'd2:  e.lo = a + b;
      4'd3:  e.lo = a - b;
      4'd4:  e.lo = a >> b[4:0];
      4'd5:  e.lo = a << b[4:0];
      4'd6:  e.lo = 32'(dbl >> b[4:0]);
      4'd7:  e.lo = 32'((dbl << b[4:0]) >> 32);
      4'd8: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        e.lo = sp[31:0]; e.hi = sp[63:32]; e.lat = MW + 1;
      end
      4'd9: begin
        if (b == 32'd0) begin
          e.err = 1'b1; e.lat = 1;
        end else begin
          e.lo = a / b; e.hi = a % b; e.lat = MW + 1;
        end
      end
      4'd10: e.lo = 32'd0 - a;
      4'd11: e.lo = ~a;
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // resp_ready driver, changed just after each rising edge.
  always @(posedge clock) begin
    #1;
    case (rr_mode)
      0: resp_ready = 1'b0;
      1: resp_ready = 1'b1;
      default: resp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: scoreboard push on accept, pop/compare on each new response.
  always @(negedge clock) begin
    if (!reset_n) begin
      sb_q.delete();
      in_resp = 1'b0;
      cur_op = 4'd0; cur_a = '0; cur_b = '0;
    end else begin
      chk("alu_operands_stable", {24'd0, alu_ctrl, alu_a, alu_b}, {24'd0, cur_op, cur_a, cur_b});
      if (resp_valid) begin
        chk("req_ready_in_done", {63'd0, req_ready}, 64'd0);
        if (!in_resp) begin
          if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_resp: got resp_valid=1, expected no response pending");
          end else begin
            mon_e = sb_q.pop_front();
            chk("resp_lo", {32'd0, resp_lo}, {32'd0, mon_e.lo});
            chk("resp_hi", {32'd0, resp_hi}, {32'd0, mon_e.hi});
            chk("resp_err", {63'd0, resp_err}, {63'd0, mon_e.err});
            chk("latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
          end
          in_resp = 1'b1;
          held = {resp_err, resp_hi, resp_lo};
        end else begin
          chk("resp_hold", {63'd0, resp_err, resp_hi, resp_lo} , {63'd0, held});
        end
        if (resp_ready) in_resp = 1'b0;
      end
      if (req_valid && req_ready) begin
        mon_e = ref_model(req_op, req_a, req_b);
        mon_e.acc_cyc = cyc;
        sb_q.push_back(mon_e);
        cur_op = req_op; cur_a = req_a; cur_b = req_b;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(posedge clock); #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clock);
    end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got req_ready=0 for 100 cycles, expected accept");
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || in_resp) && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (sb_q.size() != 0 || in_resp) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state.
    rr_mode = 1;
    repeat (3) @(negedge clock);
    chk("reset_outputs", {25'd0, alu_ctrl, alu_a, resp_err, resp_valid, req_ready},
        {25'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1});
    chk("reset_words", {alu_b, resp_lo} | {32'd0, resp_hi}, 64'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});

    // Simple add; req_ready low for exactly two cycles after accept.
    send(4'b0010, 32'd5, 32'd7);
    @(negedge clock); chk("busy_exec", {63'd0, req_ready}, 64'd0);
    @(negedge clock); chk("busy_done", {63'd0, req_ready}, 64'd0);
    @(negedge clock); chk("ready_again", {63'd0, req_ready}, 64'd1);
    drain();

    // Signed multiply, divide by zero, normal divide.
    send(4'b1000, 32'hFFFF_FFFF, 32'd2);
    drain();
    send(4'b1001, 32'd123, 32'd0);
    drain();
    send(4'b1001, 32'd100, 32'd7);
    drain();

    // rol right after a mul with a nonzero high word.
    send(4'b1000, 32'h8000_0000, 32'h0000_0100);
    send(4'b0111, 32'h8000_0001, 32'd1);
    drain();

    // Back-pressure: hold DONE for 10 cycles while new requests are waved.
    rr_mode = 0;
    send(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    n = 0;
    while (!resp_valid && n < 20) begin n++; @(negedge clock); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      req_valid = ~req_valid; req_op = 4'($urandom_range(0, 11));
      req_a = $urandom; req_b = $urandom;
      @(negedge clock);
      chk("bp_no_accept", {62'd0, req_ready, resp_valid}, {62'd0, 1'b0, 1'b1});
    end
    @(posedge clock); #1 req_valid = 1'b0;
    rr_mode = 1;
    drain();
    send(4'b0001, 32'h0000_00F0, 32'h0000_000F);
    drain();

    // Asynchronous reset in the middle of the mul/div wait window.
    send(4'b1000, 32'd3, 32'd5);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_ctl", {26'd0, alu_ctrl, alu_a, resp_err, resp_valid},
        {26'd0, 4'd0, 32'd0, 1'b0, 1'b0});
    chk("async_reset_words", {alu_b, resp_lo} | {32'd0, resp_hi}, 64'd0);
    @(negedge clock);
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_abort", {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});
    repeat (8) @(negedge clock);

    // Randomized traffic with random back-pressure.
    rr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      send(rop, ra, rb);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
